// File: rtl/simt_lane_sequencer_pkg.sv
// Shared types for the SIMT lane sequencer.
// Holds the FSM states, unit sub-op codes and a log2 helper.
package simt_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    WB
  } seq_state_t;

  // dcache sub-ops
  localparam logic [2:0] OP_LD  = 3'd0;
  localparam logic [2:0] OP_ST  = 3'd1;
  // texture sub-op
  localparam logic [2:0] OP_TEX = 3'd2;
  // SFU sub-ops
  localparam logic [2:0] OP_RCP = 3'd3;
  localparam logic [2:0] OP_RSQ = 3'd4;
  localparam logic [2:0] OP_EXP = 3'd5;
  localparam logic [2:0] OP_LOG = 3'd6;
  localparam logic [2:0] OP_SIN = 3'd7;

  // Lane index width; never below one bit.
  function automatic int clog2_lanes(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/simt_lane_sequencer_if.sv
// Bus bundle for the SIMT lane sequencer: issue, per-lane request,
// response, vector writeback and status. master = sequencer side.
interface simt_lane_sequencer_if
  import simt_seq_pkg::*;
#(
  parameter int LANES = 4,
  parameter int DW    = 32,
  parameter int RW    = 24
);
  localparam int PW = clog2_lanes(LANES);

  logic                  issue_valid_i;
  logic                  issue_ready_o;
  logic [LANES-1:0]      issue_mask_i;
  logic [2:0]            issue_op_i;
  logic [5:0]            issue_dest_i;
  logic [LANES*DW-1:0]   issue_a_i;
  logic [LANES*DW-1:0]   issue_b_i;

  logic                  req_valid_o;
  logic                  req_ready_i;
  logic [DW-1:0]         req_a_o;
  logic [DW-1:0]         req_b_o;
  logic [2:0]            req_op_o;
  logic [PW-1:0]         req_lane_o;

  logic                  rsp_valid_i;
  logic [RW-1:0]         rsp_data_i;

  logic                  wb_valid_o;
  logic                  wb_ready_i;
  logic [5:0]            wb_dest_o;
  logic [LANES*RW-1:0]   wb_data_o;
  logic [LANES-1:0]      wb_mask_o;

  logic                  busy_o;
  logic                  err_o;

  modport master (
    input  issue_valid_i, issue_mask_i, issue_op_i,
    input  issue_dest_i, issue_a_i, issue_b_i,
    output issue_ready_o,
    output req_valid_o, req_a_o, req_b_o, req_op_o, req_lane_o,
    input  req_ready_i,
    input  rsp_valid_i, rsp_data_i,
    output wb_valid_o, wb_dest_o, wb_data_o, wb_mask_o,
    input  wb_ready_i,
    output busy_o, err_o
  );

  modport slave (
    output issue_valid_i, issue_mask_i, issue_op_i,
    output issue_dest_i, issue_a_i, issue_b_i,
    input  issue_ready_o,
    input  req_valid_o, req_a_o, req_b_o, req_op_o, req_lane_o,
    output req_ready_i,
    output rsp_valid_i, rsp_data_i,
    input  wb_valid_o, wb_dest_o, wb_data_o, wb_mask_o,
    output wb_ready_i,
    input  busy_o, err_o
  );

endinterface

// File: rtl/simt_lane_sequencer_lane_priority_enc.sv
// Finds the lowest set mask lane strictly above ptr_i.
// ptr_i is one bit wider than a lane index so all-ones means "from lane 0".
module lane_priority_enc
  import simt_seq_pkg::*;
#(
  parameter int LANES = 4,
  localparam int PW   = clog2_lanes(LANES)
) (
  input  logic [LANES-1:0] mask_i,
  input  logic [PW:0]      ptr_i,
  output logic [PW-1:0]    lane_o,
  output logic             none_o
);

  logic [PW:0] start;

  // Wraps all-ones to zero for the initial pick.
  assign start = ptr_i + {{PW{1'b0}}, 1'b1};

  always_comb begin
    lane_o = '0;
    none_o = 1'b1;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (mask_i[i] && (i >= int'(start))) begin
        lane_o = PW'(i);
        none_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/simt_lane_sequencer.sv
// Serialises a masked vector op into per-lane unit requests and
// gathers in-order responses into one vector writeback.
module simt_lane_sequencer
  import simt_seq_pkg::*;
#(
  parameter int LANES   = 4,
  parameter int DW      = 32,
  parameter int RW      = 24,
  parameter int MAX_OUT = 2
) (
  input logic clk_i,
  input logic rst_i,
  simt_lane_sequencer_if.master bus
);

  localparam int PW = clog2_lanes(LANES);
  localparam int OW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int FD = 1 << OW;

  localparam logic [2:0]    MAX_CNT   = 3'(MAX_OUT);
  localparam logic [OW-1:0] LAST_SLOT = OW'(MAX_OUT - 1);
  localparam logic [PW:0]   PTR_START = '1;

  seq_state_t          state_q;
  logic [LANES-1:0]    mask_q;
  logic [2:0]          op_q;
  logic [5:0]          dest_q;
  logic [LANES*DW-1:0] a_q;
  logic [LANES*DW-1:0] b_q;
  logic [LANES*RW-1:0] res_q;
  logic [PW-1:0]       ptr_q;
  logic [2:0]          cnt_q;
  logic                err_q;

  // Lanes of in-flight requests, oldest at rd_q.
  logic [PW-1:0]       lane_fifo_q [FD];
  logic [OW-1:0]       wr_q;
  logic [OW-1:0]       rd_q;

  logic          req_valid;
  logic          req_fire;
  logic          rsp_fire;
  logic          rsp_bad;
  logic [2:0]    cnt_nxt;
  logic [PW-1:0] first_lane;
  logic          first_none;
  logic [PW-1:0] next_lane;
  logic          next_none;

  lane_priority_enc #(
    .LANES (LANES)
  ) u_first (
    .mask_i (bus.issue_mask_i),
    .ptr_i  (PTR_START),
    .lane_o (first_lane),
    .none_o (first_none)
  );

  lane_priority_enc #(
    .LANES (LANES)
  ) u_next (
    .mask_i (mask_q),
    .ptr_i  ({1'b0, ptr_q}),
    .lane_o (next_lane),
    .none_o (next_none)
  );

  // Gated on the registered count, so a slot freed by a
  // response only shows up as a request the next cycle.
  assign req_valid = (state_q == ISSUE) && (cnt_q < MAX_CNT);
  assign req_fire  = req_valid && bus.req_ready_i;
  assign rsp_fire  = bus.rsp_valid_i && (cnt_q != 3'd0);
  assign rsp_bad   = bus.rsp_valid_i && (cnt_q == 3'd0);
  assign cnt_nxt   = cnt_q + {2'b00, req_fire}
                   - {2'b00, rsp_fire};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      mask_q  <= '0;
      op_q    <= '0;
      dest_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      wr_q    <= '0;
      rd_q    <= '0;
      for (int i = 0; i < FD; i++) begin
        lane_fifo_q[i] <= '0;
      end
    end else begin
      cnt_q <= cnt_nxt;

      if (rsp_bad) err_q <= 1'b1;

      if (req_fire) begin
        lane_fifo_q[wr_q] <= ptr_q;
        wr_q <= (wr_q == LAST_SLOT) ? '0 : wr_q + 1'b1;
      end

      if (rsp_fire) begin
        res_q[lane_fifo_q[rd_q]*RW +: RW] <= bus.rsp_data_i;
        rd_q <= (rd_q == LAST_SLOT) ? '0 : rd_q + 1'b1;
      end

      unique case (state_q)
        IDLE: begin
          if (bus.issue_valid_i) begin
            mask_q  <= bus.issue_mask_i;
            op_q    <= bus.issue_op_i;
            dest_q  <= bus.issue_dest_i;
            a_q     <= bus.issue_a_i;
            b_q     <= bus.issue_b_i;
            ptr_q   <= first_lane;
            state_q <= first_none ? WB : ISSUE;
          end
        end
        ISSUE: begin
          if (req_fire) begin
            ptr_q <= next_lane;
            if (next_none) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (cnt_nxt == 3'd0) state_q <= WB;
        end
        WB: begin
          if (bus.wb_ready_i) begin
            state_q <= IDLE;
            res_q   <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.issue_ready_o = (state_q == IDLE);

  assign bus.req_valid_o = req_valid;
  assign bus.req_a_o     = a_q[ptr_q*DW +: DW];
  assign bus.req_b_o     = b_q[ptr_q*DW +: DW];
  assign bus.req_op_o    = op_q;
  assign bus.req_lane_o  = ptr_q;

  assign bus.wb_valid_o = (state_q == WB);
  assign bus.wb_dest_o  = dest_q;
  assign bus.wb_data_o  = res_q;
  assign bus.wb_mask_o  = mask_q;

  assign bus.busy_o = (state_q != IDLE);
  assign bus.err_o  = err_q;

endmodule

// File: tb/tb_simt_lane_sequencer.sv
// Directed bench for simt_lane_sequencer: transaction table plus
// hand sequences for stalls, writeback backpressure and reset.
module tb_simt_lane_sequencer;
  import simt_seq_pkg::*;

  localparam int LANES   = 4;
  localparam int DW      = 32;
  localparam int RW      = 24;
  localparam int MAX_OUT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  simt_lane_sequencer_if #(
    .LANES (LANES),
    .DW    (DW),
    .RW    (RW)
  ) bus ();

  simt_lane_sequencer #(
    .LANES   (LANES),
    .DW      (DW),
    .RW      (RW),
    .MAX_OUT (MAX_OUT)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0]  mask;
    logic [5:0]  dest;
    logic [23:0] rbase;
    logic [95:0] exp_data;
    int          exp_n;
  } vec_t;

  typedef struct {
    int          due;
    logic [23:0] data;
  } rsp_t;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_rsp_cyc = 0;
  int max_q = 0;

  rsp_t        rq[$];
  logic [1:0]  hs_lane[$];
  logic [31:0] hs_a[$];
  logic [23:0] rbase = '0;

  logic        auto_v = 1'b0;
  logic [23:0] auto_d = '0;
  logic        man_v  = 1'b0;
  logic [23:0] man_d  = '0;

  assign bus.rsp_valid_i = auto_v | man_v;
  assign bus.rsp_data_i  = auto_v ? auto_d : man_d;

  // Unit model: answers every accepted request 2 cycles later, in order.
  always @(posedge clk) begin
    if (auto_v) begin
      void'(rq.pop_front());
      last_rsp_cyc = cyc;
    end
    if (!rst && bus.req_valid_o && bus.req_ready_i) begin
      rq.push_back('{cyc + 2, rbase + 24'(bus.req_lane_o) + 24'd1});
      hs_lane.push_back(bus.req_lane_o);
      hs_a.push_back(bus.req_a_o);
      if (rq.size() > max_q) max_q = rq.size();
    end
    cyc = cyc + 1;
  end

  always @(negedge clk) begin
    if (rq.size() > 0 && rq[0].due == cyc) begin
      auto_v = 1'b1;
      auto_d = rq[0].data;
    end else begin
      auto_v = 1'b0;
    end
  end

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic issue(input logic [3:0] m, input logic [5:0] d,
                       input logic [2:0] op, input int idx);
    hs_lane.delete();
    hs_a.delete();
    max_q = 0;
    bus.issue_valid_i = 1'b1;
    bus.issue_mask_i  = m;
    bus.issue_op_i    = op;
    bus.issue_dest_i  = d;
    for (int i = 0; i < LANES; i++) begin
      bus.issue_a_i[i*DW +: DW] = 32'hA000_0000 + 32'(idx * 16 + i);
      bus.issue_b_i[i*DW +: DW] = 32'hB000_0000 + 32'(i);
    end
    step();
    bus.issue_valid_i = 1'b0;
  endtask

  task automatic wait_wb(input string nm);
    int n;
    n = 0;
    while (bus.wb_valid_o !== 1'b1 && n < 60) begin
      step();
      n++;
    end
    chk({nm, " wb_valid"}, bus.wb_valid_o, 1'b1);
  endtask

  vec_t vecs[5];

  initial begin
    logic [3:0] im;
    logic       asc;
    int         abad;
    logic [95:0] hold_d;

    vecs[0] = '{4'hF, 6'h01, 24'h000000,
                96'h000004_000003_000002_000001, 4};
    vecs[1] = '{4'hA, 6'h25, 24'h100000,
                96'h100004_000000_100002_000000, 2};
    vecs[2] = '{4'h0, 6'h3F, 24'h200000,
                96'h000000_000000_000000_000000, 0};
    vecs[3] = '{4'h8, 6'h12, 24'hABC000,
                96'hABC004_000000_000000_000000, 1};
    vecs[4] = '{4'h5, 6'h07, 24'h0F0000,
                96'h000000_0F0003_000000_0F0001, 2};

    bus.issue_valid_i = 1'b0;
    bus.issue_mask_i  = '0;
    bus.issue_op_i    = '0;
    bus.issue_dest_i  = '0;
    bus.issue_a_i     = '0;
    bus.issue_b_i     = '0;
    bus.req_ready_i   = 1'b1;
    bus.wb_ready_i    = 1'b0;

    step();
    step();
    rst = 1'b0;
    chk("rst issue_ready", bus.issue_ready_o, 1'b1);
    chk("rst req_valid", bus.req_valid_o, 1'b0);
    chk("rst wb_valid", bus.wb_valid_o, 1'b0);
    chk("rst busy", bus.busy_o, 1'b0);
    chk("rst err", bus.err_o, 1'b0);
    chk("rst wb_data", bus.wb_data_o, 96'h0);
    chk("rst wb_mask", bus.wb_mask_o, 4'h0);

    for (int v = 0; v < 5; v++) begin
      rbase = vecs[v].rbase;
      issue(vecs[v].mask, vecs[v].dest, OP_TEX, v);
      if (vecs[v].exp_n == 0) begin
        chk("zero wb next cycle", bus.wb_valid_o, 1'b1);
        chk("zero no req", bus.req_valid_o, 1'b0);
      end else begin
        chk("first req", bus.req_valid_o, 1'b1);
        wait_wb("vec");
        chk("rsp->wb latency", cyc - last_rsp_cyc, 1);
      end
      chk("wb_data", bus.wb_data_o, vecs[v].exp_data);
      chk("wb_mask", bus.wb_mask_o, vecs[v].mask);
      chk("wb_dest", bus.wb_dest_o, vecs[v].dest);
      chk("req count", hs_lane.size(), vecs[v].exp_n);
      im = '0;
      asc = 1'b1;
      abad = 0;
      for (int k = 0; k < hs_lane.size(); k++) begin
        im[hs_lane[k]] = 1'b1;
        if (k > 0 && hs_lane[k] <= hs_lane[k-1]) asc = 1'b0;
        if (hs_a[k] !== 32'hA000_0000 + 32'(v * 16)
                       + 32'(hs_lane[k])) abad++;
      end
      chk("issued lanes", im, vecs[v].mask);
      chk("lane order", asc, 1'b1);
      chk("req_a values", abad, 0);
      chk("max outstanding", max_q > MAX_OUT, 1'b0);
      chk("err clear", bus.err_o, 1'b0);
      bus.wb_ready_i = 1'b1;
      step();
      bus.wb_ready_i = 1'b0;
      chk("wb done", bus.wb_valid_o, 1'b0);
      chk("back idle", bus.issue_ready_o, 1'b1);
    end

    // Request stall on lane 0, then writeback backpressure.
    bus.req_ready_i = 1'b0;
    rbase = 24'h550000;
    issue(4'b0001, 6'h2A, OP_RCP, 7);
    for (int i = 0; i < 5; i++) begin
      chk("stall req_valid", bus.req_valid_o, 1'b1);
      chk("stall req_lane", bus.req_lane_o, 2'd0);
      chk("stall req_a", bus.req_a_o, 32'hA000_0070);
      chk("stall req_op", bus.req_op_o, OP_RCP);
      step();
    end
    chk("stall no hs", hs_lane.size(), 0);
    bus.req_ready_i = 1'b1;
    wait_wb("stall");
    hold_d = 96'h000000_000000_000000_550001;
    for (int i = 0; i < 3; i++) begin
      chk("hold wb_valid", bus.wb_valid_o, 1'b1);
      chk("hold wb_data", bus.wb_data_o, hold_d);
      chk("hold wb_mask", bus.wb_mask_o, 4'b0001);
      chk("hold wb_dest", bus.wb_dest_o, 6'h2A);
      chk("hold issue_ready", bus.issue_ready_o, 1'b0);
      step();
    end
    bus.wb_ready_i = 1'b1;
    step();
    bus.wb_ready_i = 1'b0;
    chk("hold released", bus.issue_ready_o, 1'b1);

    // Spurious response in IDLE makes err sticky.
    man_v = 1'b1;
    man_d = 24'hDEAD00;
    step();
    man_v = 1'b0;
    chk("spurious err", bus.err_o, 1'b1);
    step();
    step();
    chk("err sticky", bus.err_o, 1'b1);
    chk("spurious ignored", bus.busy_o, 1'b0);

    // Reset in DRAIN with responses still in flight.
    rbase = 24'h000000;
    issue(4'hF, 6'h01, OP_LD, 9);
    for (int n = 0; n < 40 && hs_lane.size() < 4; n++) step();
    chk("drain reached", hs_lane.size(), 4);
    chk("drain busy", bus.busy_o, 1'b1);
    chk("drain no wb", bus.wb_valid_o, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid rst issue_ready", bus.issue_ready_o, 1'b1);
    chk("mid rst req_valid", bus.req_valid_o, 1'b0);
    chk("mid rst wb_valid", bus.wb_valid_o, 1'b0);
    chk("mid rst busy", bus.busy_o, 1'b0);
    chk("mid rst err", bus.err_o, 1'b0);
    chk("mid rst wb_mask", bus.wb_mask_o, 4'h0);
    chk("mid rst wb_data", bus.wb_data_o, 96'h0);
    chk("mid rst req_lane", bus.req_lane_o, 2'd0);
    chk("mid rst req_a", bus.req_a_o, 32'h0);
    for (int n = 0; n < 4 && bus.err_o !== 1'b1; n++) step();
    chk("late rsp err", bus.err_o, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/simt_lane_sequencer.md
Name: simt_lane_sequencer

Overview:
- Parametrised successor to the fragment control unit's MEM/SFU serialisation path.
- Accepts one vector instruction covering LANES threads and serialises it into per-lane requests to a single-channel unit (dcache, texture or SFU), using a valid/ready handshake.
- Allows up to MAX_OUT requests in flight and skips lanes that are masked off.
- Gathers the in-order responses into one vector writeback for the register-file banks.

Parameters:
- LANES, 4: number of SIMT lanes; power of two, at least 2.
- DW, 32: operand width per lane.
- RW, 24: result width per lane.
- MAX_OUT, 2: maximum number of outstanding requests, 1 to 4.

Ports:
- clk_i  in  1  core clock
- rst_i  in  1  reset; one clock, synchronous, active-high
- issue_valid_i  in  1  vector instruction offered
- issue_ready_o  out  1  sequencer can accept an instruction
- issue_mask_i  in  LANES  active-lane mask
- issue_op_i  in  3  unit sub-op, passed through unchanged
- issue_dest_i  in  6  destination register; bit 5 selects the bank
- issue_a_i  in  LANES*DW  operand A, lane i at bits [DW*(i+1)-1:DW*i]
- issue_b_i  in  LANES*DW  operand B, same lane packing
- req_valid_o  out  1  per-lane request valid
- req_ready_i  in  1  unit accepts the request
- req_a_o  out  DW  lane operand A
- req_b_o  out  DW  lane operand B
- req_op_o  out  3  sub-op
- req_lane_o  out  $clog2(LANES)  lane index of the request
- rsp_valid_i  in  1  response valid; responses arrive in request order
- rsp_data_i  in  RW  response data
- wb_valid_o  out  1  vector writeback valid
- wb_ready_i  in  1  register file accepts the writeback
- wb_dest_o  out  6  destination register
- wb_data_o  out  LANES*RW  gathered results, same lane packing as operands
- wb_mask_o  out  LANES  lanes whose results are valid
- busy_o  out  1  high in any state other than IDLE
- err_o  out  1  sticky: a response arrived with nothing outstanding

Behaviour:
- Reset values: state IDLE; all valid outputs 0; issue_ready_o 1; err_o 0; outstanding count 0; lane pointer 0; data registers 0.
- States: IDLE, ISSUE, DRAIN, WB.
- IDLE:
  - issue_ready_o = 1.
  - An issue is accepted when issue_valid_i is high; mask, op, dest, A and B are latched that cycle.
  - Non-zero mask: go to ISSUE.
  - Zero mask: go to WB, with wb_mask_o = 0 and wb_data_o = 0.
- ISSUE:
  - issue_ready_o = 0.
  - The lane pointer holds the lowest set mask bit not yet issued.
  - req_valid_o = 1 whenever outstanding < MAX_OUT.
  - req_a_o, req_b_o, req_op_o and req_lane_o stay stable while req_valid_o is high and req_ready_i is low.
  - On req_valid_o && req_ready_i, the pointer advances to the next set bit, skipping cleared lanes.
  - After the last active lane is accepted: go to DRAIN.
  - First req_valid_o is asserted the cycle after the issue is accepted.
- Responses:
  - Each rsp_valid_i writes rsp_data_i into the slot of the oldest outstanding lane.
  - Lane indices are tracked in a MAX_OUT-deep FIFO.
  - Responses are accepted in ISSUE and in DRAIN.
- Outstanding count:
  - +1 on a request handshake, -1 on a response.
  - A handshake and a response in the same cycle leave the count unchanged.
  - A response in the same cycle that frees a slot may be followed by a new request in the next cycle, not the same one.
- DRAIN:
  - When outstanding reaches 0, go to WB the next cycle.
  - Response-to-wb_valid_o latency for the last lane is 1 cycle.
- WB:
  - wb_valid_o = 1, and wb_dest_o, wb_data_o and wb_mask_o are held until wb_ready_i.
  - On the handshake: go to IDLE and clear the result slots.
  - issue_ready_o stays 0 in WB; there is no back-to-back accept in the same cycle.
- Error cases:
  - rsp_valid_i with outstanding = 0 (any state) is ignored and sets err_o; only rst_i clears err_o.
  - Masked-off lanes in wb_data_o read 0.
- Reset mid-operation: everything is discarded, including in-flight requests. Responses arriving after reset count as spurious and set err_o.
- Width rules: DW and RW are independent. No truncation or extension is performed inside the block.

Decomposition:
- Package simt_seq_pkg:
  - seq_state_t enum {IDLE, ISSUE, DRAIN, WB}.
  - localparam sub-op codes for the dcache load/store, texture lookup and SFU ops.
  - Function clog2_lanes.
- Sub-module lane_priority_enc:
  - Combinational; input mask, input pointer.
  - Outputs: next set lane at or above pointer+1, plus a "none" flag.
  - Used for both the initial pick and each advance.
- Outstanding-lane FIFO is written inline; no separate module.

Test Plan:
- Mask 4'b1111, req_ready_i always 1, responses 0x000001..0x000004 each 2 cycles after the request:
  - req_lane_o sequence 0,1,2,3.
  - Never more than 2 outstanding.
  - wb_data_o = {0x000004, 0x000003, 0x000002, 0x000001}, wb_mask_o = 4'b1111.
- Mask 4'b1010, dest 6'h25:
  - Only lanes 1 and 3 are requested.
  - wb_data_o lanes 0 and 2 = 0; wb_mask_o = 4'b1010; wb_dest_o = 6'h25.
- Mask 4'b0000:
  - No req_valid_o.
  - wb_valid_o the cycle after accept, with wb_mask_o = 0.
- req_ready_i low for 5 cycles with lane 0 pending:
  - req_a_o and req_lane_o stay stable.
  - wb_ready_i held low 3 cycles in WB: outputs stay stable and issue_ready_o = 0.
- Response injected in IDLE:
  - err_o rises and stays 1.
  - Assert rst_i mid-DRAIN: all outputs return to reset values next cycle and err_o = 0.
